// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer: select encodings
// and default sizing.
package demux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/demux1to2_stream_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; head word is forced to
// zero while empty so an idle output never shows stale data.
module stream_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/demux1to2_stream.sv
// Buffered 1-to-2 stream demultiplexer: each input word is steered by its
// select bit into the A or B output FIFO; per-output delivery counters.
module demux1to2_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic             full_a, full_b;
  logic             empty_a, empty_b;
  logic             push_a, push_b;
  logic             pop_a, pop_b;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  // Ready depends only on the selected target, never on in_valid.
  assign in_ready = (in_sel == SEL_B) ? !full_b : !full_a;

  assign push_a = in_valid && in_ready && (in_sel == SEL_A);
  assign push_b = in_valid && in_ready && (in_sel == SEL_B);

  assign out_a_valid = !empty_a;
  assign out_b_valid = !empty_b;
  assign pop_a       = out_a_valid && out_a_ready;
  assign pop_b       = out_b_valid && out_b_ready;

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_a),
    .push_data_i (in_data),
    .pop_i       (pop_a),
    .full_o      (full_a),
    .empty_o     (empty_a),
    .head_o      (out_a_data)
  );

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_b),
    .push_data_i (in_data),
    .pop_i       (pop_b),
    .full_o      (full_b),
    .empty_o     (empty_b),
    .head_o      (out_b_data)
  );

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (pop_a) cnt_a_d = cnt_a_q + CNT_W'(1);
    if (pop_b) cnt_b_d = cnt_b_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;

endmodule
